// File: rtl/dp_exec_unit.sv
// Self-sequencing datapath: register file, A/B/C operand registers, shifter, ALU and
// Z/N/V flags. Each accepted command runs through IDLE -> [RD_A] -> [RD_B] -> EXEC -> WB.
module dp_exec_unit #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rn,
  input  logic [AW-1:0]    cmd_rm,
  input  logic [1:0]       cmd_shift,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [WIDTH-1:0] ext_data,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z_out,
  output logic             n_out,
  output logic             v_out,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [2:0]       dbg_state
);

  // Handshake: a command is taken on the rising edge where cmd_valid && cmd_ready.
  // cmd_ready is high only in IDLE outside reset; an issuer seeing it low must hold
  // cmd_valid and all cmd_* fields until the accept edge.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_MOV_IMM = 3'b000,
    OP_MOV     = 3'b001,
    OP_ADD     = 3'b010,
    OP_CMP     = 3'b011,
    OP_AND     = 3'b100,
    OP_MVN     = 3'b101,
    OP_ADD_IMM = 3'b110,
    OP_LOAD    = 3'b111
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [AW-1:0]    rd_q, rn_q, rm_q;
  logic [1:0]       shift_q;
  logic [WIDTH-1:0] imm_q, ext_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             z_q, n_q, v_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic             accept;
  logic [WIDTH-1:0] sh, diff, exec_res;
  logic             diff_v;

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state == WB) && !reset;
  assign result    = c_q;
  assign z_out     = z_q;
  assign n_out     = n_q;
  assign v_out     = v_q;
  assign dbg_data  = regs[dbg_addr];
  assign dbg_state = state;

  // Shifter on B only; LSL fills with zero, ASR replicates the sign bit.
  always_comb begin
    sh = b_q;
    case (shift_q)
      2'b01:   sh = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   sh = {1'b0, b_q[WIDTH-1:1]};
      2'b11:   sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: sh = b_q;
    endcase
  end

  assign diff   = a_q - sh;
  assign diff_v = (a_q[WIDTH-1] != sh[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    exec_res = '0;
    case (op_q)
      OP_MOV_IMM: exec_res = imm_q;
      OP_MOV:     exec_res = sh;
      OP_ADD:     exec_res = a_q + sh;
      OP_CMP:     exec_res = diff;
      OP_AND:     exec_res = a_q & sh;
      OP_MVN:     exec_res = ~sh;
      OP_ADD_IMM: exec_res = a_q + imm_q;
      OP_LOAD:    exec_res = ext_q;
      default:    exec_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_t'(cmd_op))
            OP_ADD, OP_CMP, OP_AND, OP_ADD_IMM: state_nxt = RD_A;
            OP_MOV, OP_MVN:                     state_nxt = RD_B;
            default:                            state_nxt = EXEC;
          endcase
        end
      end
      RD_A:    state_nxt = (op_q == OP_ADD_IMM) ? EXEC : RD_B;
      RD_B:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= OP_MOV_IMM;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      imm_q   <= '0;
      ext_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= op_t'(cmd_op);
        rd_q    <= cmd_rd;
        rn_q    <= cmd_rn;
        rm_q    <= cmd_rm;
        shift_q <= cmd_shift;
        imm_q   <= cmd_imm;
        ext_q   <= ext_data;
      end
      case (state)
        RD_A: a_q <= regs[rn_q];
        RD_B: b_q <= regs[rm_q];
        EXEC: begin
          c_q <= exec_res;
          if (op_q == OP_CMP) begin
            z_q <= (diff == '0);
            n_q <= diff[WIDTH-1];
            v_q <= diff_v;
          end
        end
        WB: if (op_q != OP_CMP) regs[rd_q] <= c_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_exec_unit.sv
// Directed bench for dp_exec_unit: hand-computed register, flag, latency and
// handshake expectations for the default 16-bit, 8-register configuration.
module tb_dp_exec_unit;

  localparam int W = 16;
  localparam logic [2:0] MOV_IMM = 3'b000, MOV = 3'b001, ADD = 3'b010, CMP = 3'b011,
                         AND_OP = 3'b100, MVN = 3'b101, ADD_IMM = 3'b110, LOAD = 3'b111;
  localparam logic [1:0] SH_NONE = 2'b00, SH_LSL = 2'b01, SH_LSR = 2'b10, SH_ASR = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [2:0]   cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
  logic [1:0]   cmd_shift = '0;
  logic [W-1:0] cmd_imm = '0, ext_data = '0;
  logic         done;
  logic [W-1:0] result;
  logic         z_out, n_out, v_out;
  logic [2:0]   dbg_addr = '0;
  logic [W-1:0] dbg_data;
  logic [2:0]   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  logic [W-1:0] exp_q[$];

  dp_exec_unit #(.WIDTH(W), .NREGS(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .ext_data(ext_data),
    .done(done), .result(result), .z_out(z_out), .n_out(n_out), .v_out(v_out),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: present a command at a negedge, hold until accepted, then scramble inputs.
  task automatic launch(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                        input logic [2:0] rm, input logic [1:0] sh, input logic [W-1:0] imm,
                        input logic [W-1:0] ext);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
    cmd_shift = sh; cmd_imm = imm; ext_data = ext;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check_val("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_rd    = 3'($urandom_range(0, 7));
    cmd_rn    = 3'($urandom_range(0, 7));
    cmd_rm    = 3'($urandom_range(0, 7));
    cmd_shift = 2'($urandom_range(0, 3));
    cmd_imm   = W'($urandom_range(0, 65535));
    ext_data  = '0;
  endtask

  // Called at the negedge of the first cycle after accept; returns at the done negedge.
  task automatic wait_done(output int l);
    l = 1;
    while (!done && l < 12) begin
      check_val("busy_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      l++;
    end
    check_val("done_seen", 32'(done), 32'd1);
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                      input logic [2:0] rm, input logic [1:0] sh, input logic [W-1:0] imm,
                      input logic [W-1:0] ext, input int exp_lat, input string tag);
    launch(op, rd, rn, rm, sh, imm, ext);
    wait_done(lat);
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
  endtask

  task automatic check_reg(input logic [2:0] addr, input logic [W-1:0] exp, input string tag);
    dbg_addr = addr;
    #1;
    check_val(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic check_flags(input logic z, input logic n, input logic v, input string tag);
    check_val({tag, "_znv"}, {29'd0, z_out, n_out, v_out}, {29'd0, z, n, v});
  endtask

  initial begin
    // 1: reset behaviour
    repeat (2) begin
      @(negedge clk);
      check_val("rst_ready", 32'(cmd_ready), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
    end
    cmd_valid = 1'b1;
    @(negedge clk);
    check_val("rst_valid_ignored", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", 32'(cmd_ready), 32'd1);
    check_val("post_rst_done", 32'(done), 32'd0);
    check_val("post_rst_result", 32'(result), 32'd0);
    check_flags(1'b0, 1'b0, 1'b0, "post_rst");
    for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000, "rst_reg");

    // 2: MOV_IMM, MOV_IMM, ADD with LSL1
    send(MOV_IMM, 3'd0, 3'd0, 3'd0, SH_NONE, 16'h0007, 16'h0, 2, "movi_r0");
    send(MOV_IMM, 3'd1, 3'd0, 3'd0, SH_NONE, 16'h0002, 16'h0, 2, "movi_r1");
    send(ADD, 3'd2, 3'd0, 3'd1, SH_LSL, 16'h0000, 16'h0, 4, "add_lsl");
    check_val("add_result", 32'(result), 32'h000B);
    check_reg(3'd2, 16'h000B, "add_r2");
    check_flags(1'b0, 1'b0, 1'b0, "add");

    // 3: CMP with signed overflow, then CMP equal; rd must not be written
    send(MOV_IMM, 3'd3, 3'd0, 3'd0, SH_NONE, 16'h7FFF, 16'h0, 2, "movi_r3");
    send(MOV_IMM, 3'd4, 3'd0, 3'd0, SH_NONE, 16'hFFFF, 16'h0, 2, "movi_r4");
    send(CMP, 3'd2, 3'd3, 3'd4, SH_NONE, 16'h0000, 16'h0, 4, "cmp_ovf");
    check_flags(1'b0, 1'b1, 1'b1, "cmp_ovf");
    check_val("cmp_ovf_result", 32'(result), 32'h8000);
    check_reg(3'd2, 16'h000B, "cmp_no_write");
    send(CMP, 3'd3, 3'd0, 3'd0, SH_NONE, 16'h0000, 16'h0, 4, "cmp_eq");
    check_flags(1'b1, 1'b0, 1'b0, "cmp_eq");
    check_reg(3'd3, 16'h7FFF, "cmp_eq_no_write");

    // 4: MVN of ASR1, LOAD with ext_data changed after accept, MOV LSR1, AND
    send(MOV_IMM, 3'd6, 3'd0, 3'd0, SH_NONE, 16'h8000, 16'h0, 2, "movi_r6");
    send(MVN, 3'd5, 3'd0, 3'd6, SH_ASR, 16'h0000, 16'h0, 3, "mvn_asr");
    check_reg(3'd5, 16'h3FFF, "mvn_r5");
    check_flags(1'b1, 1'b0, 1'b0, "mvn_keep");
    send(LOAD, 3'd7, 3'd0, 3'd0, SH_NONE, 16'h0000, 16'hBEEF, 2, "load");
    check_reg(3'd7, 16'hBEEF, "load_r7");
    send(MOV, 3'd4, 3'd0, 3'd3, SH_LSR, 16'h0000, 16'h0, 3, "mov_lsr");
    check_reg(3'd4, 16'h3FFF, "mov_lsr_r4");
    send(AND_OP, 3'd4, 3'd7, 3'd6, SH_NONE, 16'h0000, 16'h0, 4, "and");
    check_reg(3'd4, 16'h8000, "and_r4");

    // 5: back-to-back ADD_IMM with cmd_valid held high
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0004);
    launch(ADD_IMM, 3'd1, 3'd1, 3'd0, SH_NONE, 16'h0001, 16'h0);
    cmd_valid = 1'b1;
    cmd_op = ADD_IMM; cmd_rd = 3'd1; cmd_rn = 3'd1; cmd_rm = 3'd0;
    cmd_shift = SH_NONE; cmd_imm = 16'h0001;
    wait_done(lat);
    check_val("b2b_first_lat", 32'(lat), 32'd3);
    check_val("b2b_first_result", 32'(result), 32'(exp_q.pop_front()));
    @(negedge clk);
    check_val("b2b_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check_val("b2b_accepted", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    wait_done(lat);
    check_val("b2b_second_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check_reg(3'd1, exp_q.pop_front(), "b2b_r1");

    // 6: reset during EXEC aborts the command and clears everything
    send(MOV_IMM, 3'd2, 3'd0, 3'd0, SH_NONE, 16'h1234, 16'h0, 2, "movi_r2");
    check_reg(3'd2, 16'h1234, "pre_abort_r2");
    launch(ADD, 3'd2, 3'd0, 3'd1, SH_NONE, 16'h0000, 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val("abort_done", 32'(done), 32'd0);
      check_val("abort_ready", 32'(cmd_ready), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_val("abort_ready_after", 32'(cmd_ready), 32'd1);
    check_val("abort_result", 32'(result), 32'd0);
    check_flags(1'b0, 1'b0, 1'b0, "abort");
    for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000, "abort_reg");
    repeat (4) begin
      @(negedge clk);
      check_val("abort_no_done", 32'(done), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dp_exec_unit.md
# dp_exec_unit

Parametrised, self-sequencing successor to the 16-bit, 8-register CPU datapath. Width and register count are parameters. The unit holds the register file, A/B/C operand registers, shifter, ALU and Z/N/V status. An internal FSM runs each accepted command through read, execute and write-back, so the CPU controller only issues a command via valid/ready and waits for `done`.

## Interface
- `WIDTH`, 16, datapath and register width (≥4)
- `NREGS`, 8, register count (power of two, ≥2); `AW = $clog2(NREGS)` is a derived localparam

- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: unit idle, can accept
- `cmd_op` in 3: 000 MOV_IMM, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110 ADD_IMM, 111 LOAD
- `cmd_rd`, `cmd_rn`, `cmd_rm` in AW: destination, first source, second (shifted) source
- `cmd_shift` in 2: applied to Rm: 00 none, 01 LSL1 (0-fill), 10 LSR1, 11 ASR1
- `cmd_imm` in WIDTH: pre-sign-extended immediate
- `ext_data` in WIDTH: memory data for LOAD
- `done` out 1: one-cycle pulse in WB cycle
- `result` out WIDTH: C register
- `z_out`, `n_out`, `v_out` out 1: status flags
- `dbg_addr` in AW; `dbg_data` out WIDTH: combinational register-file read port

## Operation
- Accept on rising edge with `cmd_valid && cmd_ready`. All cmd_* fields and `ext_data` are captured into a command register at accept; later input changes have no effect.
- FSM states: IDLE, RD_A, RD_B, EXEC, WB.
- Transitions:
  - IDLE→RD_A: ADD, CMP, AND, ADD_IMM
  - IDLE→RD_B: MOV, MVN
  - IDLE→EXEC: MOV_IMM, LOAD
  - RD_A→RD_B, except ADD_IMM: RD_A→EXEC
  - RD_B→EXEC
  - EXEC→WB
  - WB→IDLE
- RD_A: A ← R[rn]. RD_B: B ← R[rm].
- EXEC: C ← op result, where sh = shift(B):
  - MOV_IMM: imm
  - MOV: sh
  - ADD: A+sh
  - CMP: A−sh
  - AND: A&sh
  - MVN: ~sh
  - ADD_IMM: A+imm
  - LOAD: ext_data
- Arithmetic is modulo 2^WIDTH; the carry is discarded.
- Flags update only in EXEC of CMP:
  - Z = (A−sh == 0)
  - N = MSB of difference
  - V = signed overflow of the subtraction
- All other ops leave the flags unchanged.
- On CMP, C is also loaded with the difference. `cmd_ready` is 1 only in IDLE.
- WB: `done`=1. R[rd] ← C at end of cycle for all ops except CMP, which writes nothing.
- Shift uses only Rm, never the immediate. ASR1 replicates the MSB.
- rd may equal rn/rm; sources are read before WB, so no hazard exists.

## Timing
- Latency, counted in cycles after the accept edge, with `done` in the last one:
  - register-register (ADD/CMP/AND): 4
  - MOV/MVN/ADD_IMM: 3
  - MOV_IMM/LOAD: 2
- Written register is visible on `dbg_data` the cycle after `done`. A command accepted at the earliest point (cycle after `done`) sees the new value.
- Back-to-back throughput is one command per latency+1 cycles, including the IDLE cycle.
- `result` holds its value until the next EXEC.
- Reset behaviour:
  - While `reset` is high: state=IDLE, all registers/A/B/C=0, flags=0, `done`=0, `cmd_ready`=0.
  - `cmd_ready`=1 the first cycle after deassert.
  - Reset mid-command aborts it: no write-back, no `done`.
- `cmd_valid` during reset is ignored.
- `cmd_valid` while busy is not accepted and must be held by the issuer.

## Test plan
1. Reset 2 cycles, deassert → `cmd_ready`=1 next cycle; `dbg_data`=0x0000 for addr 0–7; z/n/v=0; `done` never pulses.
2. MOV_IMM R0=0x0007, MOV_IMM R1=0x0002, ADD R2=R0+(R1 LSL1) → `done` 4 cycles after ADD accept, `result`=0x000B, R2=0x000B, flags unchanged.
3. R3=0x7FFF, R4=0xFFFF, CMP R3,R4 → z=0, n=1, v=1, no register changes; then CMP R0,R0 with R0=0x0007 → z=1, n=0, v=0.
4. R6=0x8000, MVN R5=~(R6 ASR1) → latency 3, R5=0x3FFF; LOAD R7 with `ext_data`=0xBEEF changed to 0x0000 one cycle after accept → R7=0xBEEF, latency 2.
5. `cmd_valid` held high: ADD_IMM R1=R1+0x0001 (R1=0x0002) then ADD_IMM R1=R1+0x0001 → `cmd_ready` low through busy, second accepted the cycle after first `done`, final R1=0x0004.
6. ADD R2=R0+R1 with R2=0x1234 beforehand, reset asserted in EXEC → no `done`, all registers 0 including R2, `result`=0, `cmd_ready`=1 the cycle after deassert.
